// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and data access.
// Data is served before fetch; results are presented together in a one-cycle DONE window.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    input  logic              mem_ce,
    input  logic              mem_wrn,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wrdata,
    output logic [DATA_W-1:0] mem_rddata,
    output logic              mem_valid,
    output logic              stall_req,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              timeout_err
);

    // The watchdog only needs to count 0..MAX_WAIT-1; the final wait cycle is detected by compare.
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_INST,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_pi;
    logic              r_dataSrv;
    logic [ADDR_W-1:0] r_ifAddr;
    logic [CNT_W-1:0]  r_wdCnt;

    logic              w_busy;
    logic              w_timeout;
    logic              w_accDone;
    logic [DATA_W-1:0] w_rdResult;

    assign w_busy     = (r_state == S_DATA) || (r_state == S_INST);
    // An ack arriving on the last permitted cycle wins over the watchdog.
    assign w_timeout  = w_busy && !ram_ack && (r_wdCnt == WD_LAST);
    assign w_accDone  = w_busy && (ram_ack || w_timeout);
    assign w_rdResult = ram_ack ? ram_rdata : '0;

    assign stall_req = ((r_state == S_IDLE) && (mem_ce || if_en)) ||
                       (r_state == S_DATA) || (r_state == S_INST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_ce) begin
                    w_nextState = S_DATA;
                end else if (if_en) begin
                    w_nextState = S_INST;
                end
            end
            S_DATA: begin
                if (w_accDone) begin
                    w_nextState = r_pi ? S_INST : S_DONE;
                end
            end
            S_INST: begin
                if (w_accDone) begin
                    w_nextState = S_DONE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Bus, result and watchdog registers; valid pulses default low so they last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            if_inst     <= '0;
            mem_rddata  <= '0;
            if_valid    <= 1'b0;
            mem_valid   <= 1'b0;
            timeout_err <= 1'b0;
            r_pi        <= 1'b0;
            r_dataSrv   <= 1'b0;
            r_ifAddr    <= '0;
            r_wdCnt     <= '0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pi      <= if_en;
                    r_dataSrv <= mem_ce;
                    r_ifAddr  <= if_addr;
                    r_wdCnt   <= '0;
                    if (mem_ce) begin
                        ram_req   <= 1'b1;
                        ram_we    <= mem_wrn;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wrdata;
                    end else if (if_en) begin
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= if_addr;
                    end
                end
                S_DATA: begin
                    if (w_accDone) begin
                        if (!ram_we) begin
                            mem_rddata <= w_rdResult;
                        end
                        if (w_timeout) begin
                            timeout_err <= 1'b1;
                        end
                        r_wdCnt <= '0;
                        ram_we  <= 1'b0;
                        if (r_pi) begin
                            ram_addr <= r_ifAddr;
                        end else begin
                            ram_req   <= 1'b0;
                            mem_valid <= 1'b1;
                        end
                    end else begin
                        r_wdCnt <= r_wdCnt + CNT_W'(1);
                    end
                end
                S_INST: begin
                    if (w_accDone) begin
                        if_inst <= w_rdResult;
                        if (w_timeout) begin
                            timeout_err <= 1'b1;
                        end
                        r_wdCnt   <= '0;
                        r_pi      <= 1'b0;
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        if_valid  <= 1'b1;
                        mem_valid <= r_dataSrv;
                    end else begin
                        r_wdCnt <= r_wdCnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_dataSrv <= 1'b0;
                end
            endcase
        end
    end

endmodule
